// File: rtl/axi_req_arbiter_if.sv
// Requester-side and AXI-side signal bundle for axi_req_arbiter.
// master: the arbiter's view; slave: the requesters plus the AXI fabric.
interface axi_req_arbiter_if #(
    parameter int GRLEN = 32
);
    logic             inst_req;
    logic [GRLEN-1:0] inst_addr;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [GRLEN-1:0] inst_rdata;

    logic             data_req;
    logic             data_wr;
    logic [3:0]       data_wstrb;
    logic [GRLEN-1:0] data_addr;
    logic [GRLEN-1:0] data_wdata;
    logic             data_addr_ok;
    logic             data_data_ok;
    logic [GRLEN-1:0] data_rdata;
    logic             resp_err;

    logic [3:0]       arid;
    logic [GRLEN-1:0] araddr;
    logic             arvalid;
    logic             arready;

    logic [3:0]       rid;
    logic [GRLEN-1:0] rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    logic [GRLEN-1:0] awaddr;
    logic             awvalid;
    logic             awready;

    logic [GRLEN-1:0] wdata;
    logic [3:0]       wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;

    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata, resp_err,
        output arid, araddr, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata, resp_err,
        input  arid, araddr, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_req_arbiter.sv
// Single-outstanding AXI sequencer sharing one port between IFU and LSU (LSU priority).
// Define AXI_ARB_STARVE_EN to force an IFU grant after STARVE_MAX back-to-back LSU grants.
module axi_req_arbiter #(
    parameter int GRLEN      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_req_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_RESP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [GRLEN-1:0] r_addr;
    logic [GRLEN-1:0] r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_owner;      // 1: LSU owns the bus
    logic             r_aw_done;
    logic             r_w_done;

    logic w_idle, w_force_ifu, w_gnt_lsu, w_gnt_ifu;
    logic w_aw_hs, w_w_hs, w_wr_addr_done;
    logic w_rd_fin, w_wr_fin;
    logic w_unused;

    assign w_unused = ^{bus.rid, bus.rlast, 1'(STARVE_MAX)};

`ifdef AXI_ARB_STARVE_EN
    logic [2:0] r_starve;

    assign w_force_ifu = bus.inst_req && (r_starve == 3'(STARVE_MAX));

    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_starve <= 3'd0;
        else if (w_gnt_ifu)
            r_starve <= 3'd0;
        else if (w_gnt_lsu && bus.inst_req && r_starve != 3'd7)
            r_starve <= r_starve + 3'd1;
    end
`else
    assign w_force_ifu = 1'b0;
`endif

    // Grants are gated by reset so nothing is accepted while the FSM is being cleared.
    assign w_idle    = (r_state == S_IDLE) && aresetn;
    assign w_gnt_lsu = w_idle && bus.data_req && !w_force_ifu;
    assign w_gnt_ifu = w_idle && bus.inst_req && !w_gnt_lsu;

    assign w_aw_hs        = bus.awvalid && bus.awready;
    assign w_w_hs         = bus.wvalid && bus.wready;
    assign w_wr_addr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    assign w_rd_fin = (r_state == S_RD_DATA) && bus.rvalid && aresetn;
    assign w_wr_fin = (r_state == S_WR_RESP) && bus.bvalid && aresetn;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= 4'd0;
            r_owner   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_lsu || w_gnt_ifu) begin
                r_owner <= w_gnt_lsu;
                r_addr  <= w_gnt_lsu ? bus.data_addr : bus.inst_addr;
                r_wdata <= bus.data_wdata;
                r_wstrb <= bus.data_wstrb;
            end
            if (r_state == S_WR_ADDR) begin
                if (w_wr_addr_done) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_aw_done <= r_aw_done || w_aw_hs;
                    r_w_done  <= r_w_done || w_w_hs;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_lsu)
                    w_state_nxt = bus.data_wr ? S_WR_ADDR : S_RD_ADDR;
                else if (w_gnt_ifu)
                    w_state_nxt = S_RD_ADDR;
            end
            S_RD_ADDR: if (bus.arvalid && bus.arready) w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (bus.rvalid) w_state_nxt = S_IDLE;
            S_WR_ADDR: if (w_wr_addr_done) w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (bus.bvalid) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.inst_addr_ok = w_gnt_ifu;
        bus.data_addr_ok = w_gnt_lsu;

        bus.arid    = {3'd0, r_owner};
        bus.araddr  = r_addr;
        bus.arvalid = (r_state == S_RD_ADDR);
        bus.rready  = (r_state == S_RD_DATA);

        bus.awaddr  = r_addr;
        bus.awvalid = (r_state == S_WR_ADDR) && !r_aw_done;
        bus.wdata   = r_wdata;
        bus.wstrb   = r_wstrb;
        bus.wlast   = 1'b1;
        bus.wvalid  = (r_state == S_WR_ADDR) && !r_w_done;
        bus.bready  = (r_state == S_WR_RESP);

        bus.inst_data_ok = w_rd_fin && !r_owner;
        bus.data_data_ok = (w_rd_fin && r_owner) || w_wr_fin;
        bus.inst_rdata   = bus.inst_data_ok ? bus.rdata : '0;
        bus.data_rdata   = bus.data_data_ok ? bus.rdata : '0;
        bus.resp_err     = (w_rd_fin && (bus.rresp != 2'd0)) ||
                           (w_wr_fin && (bus.bresp != 2'd0));
    end
endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_axi_req_arbiter;
    localparam int GRLEN = 32;
    localparam int SMAX  = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_req_arbiter_if #(.GRLEN(GRLEN)) bus();

    axi_req_arbiter #(.GRLEN(GRLEN), .STARVE_MAX(SMAX)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.master)
    );

    int n_tot = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: at most one transaction in flight, described by its owner, kind and
    // which half (address phase / response phase) it is in.
    bit        m_busy = 0, m_owner = 0, m_wr = 0, m_addr_done = 0, m_aw = 0, m_w = 0;
    bit [31:0] m_addr = 0, m_wdata = 0;
    bit [3:0]  m_wstrb = 0;
    int        m_cnt = 0;

    logic m_force, e_dg, e_ig, e_arv, e_rr, e_awv, e_wv, e_br, e_rfin, e_wfin;
`ifdef AXI_ARB_STARVE_EN
    assign m_force = bus.inst_req && (m_cnt >= SMAX);
`else
    assign m_force = 1'b0;
`endif
    always_comb begin
        e_dg   = !m_busy && aresetn && bus.data_req && !m_force;
        e_ig   = !m_busy && aresetn && bus.inst_req && !e_dg;
        e_arv  = m_busy && !m_wr && !m_addr_done;
        e_rr   = m_busy && !m_wr && m_addr_done;
        e_awv  = m_busy && m_wr && !m_addr_done && !m_aw;
        e_wv   = m_busy && m_wr && !m_addr_done && !m_w;
        e_br   = m_busy && m_wr && m_addr_done;
        e_rfin = e_rr && bus.rvalid && aresetn;
        e_wfin = e_br && bus.bvalid && aresetn;
    end

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_busy <= 0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (e_dg || e_ig) begin
                m_busy      <= 1;
                m_owner     <= e_dg;
                m_wr        <= e_dg && bus.data_wr;
                m_addr      <= e_dg ? bus.data_addr : bus.inst_addr;
                m_wdata     <= bus.data_wdata;
                m_wstrb     <= bus.data_wstrb;
                m_addr_done <= 0;
                m_aw        <= 0;
                m_w         <= 0;
                m_cnt       <= e_ig ? 0 : (bus.inst_req ? m_cnt + 1 : m_cnt);
            end
        end else if (!m_addr_done) begin
            if (!m_wr) m_addr_done <= bus.arready;
            else begin
                m_aw        <= m_aw | bus.awready;
                m_w         <= m_w | bus.wready;
                m_addr_done <= (m_aw | bus.awready) & (m_w | bus.wready);
            end
        end else if (e_rfin || e_wfin) begin
            m_busy <= 0;
        end
    end

    always @(negedge aclk) begin
        if (run) begin
            chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(e_ig));
            chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(e_dg));
            chk("arvalid", 32'(bus.arvalid), 32'(e_arv));
            if (e_arv) begin
                chk("araddr", bus.araddr, m_addr);
                chk("arid", 32'(bus.arid), 32'(m_owner));
            end
            chk("rready", 32'(bus.rready), 32'(e_rr));
            chk("awvalid", 32'(bus.awvalid), 32'(e_awv));
            chk("wvalid", 32'(bus.wvalid), 32'(e_wv));
            if (e_awv) chk("awaddr", bus.awaddr, m_addr);
            if (e_wv) begin
                chk("wdata", bus.wdata, m_wdata);
                chk("wstrb", 32'(bus.wstrb), 32'(m_wstrb));
                chk("wlast", 32'(bus.wlast), 32'd1);
            end
            chk("bready", 32'(bus.bready), 32'(e_br));
            chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(e_rfin && !m_owner));
            chk("data_data_ok", 32'(bus.data_data_ok), 32'((e_rfin && m_owner) || e_wfin));
            chk("inst_rdata", bus.inst_rdata, (e_rfin && !m_owner) ? bus.rdata : 32'd0);
            chk("data_rdata", bus.data_rdata, ((e_rfin && m_owner) || e_wfin) ? bus.rdata : 32'd0);
            chk("resp_err", 32'(bus.resp_err),
                32'((e_rfin && bus.rresp != 0) || (e_wfin && bus.bresp != 0)));
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    int n_ifu, n_lsu;

    initial begin
        bus.inst_req = 0; bus.inst_addr = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_wstrb = 0; bus.data_addr = 0; bus.data_wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;

        step();
        run = 1;
        step();
        #2;
        chk("rst arvalid", 32'(bus.arvalid), 0);
        chk("rst rready", 32'(bus.rready), 0);
        chk("rst awvalid", 32'(bus.awvalid), 0);
        chk("rst wvalid", 32'(bus.wvalid), 0);
        chk("rst bready", 32'(bus.bready), 0);
        step();
        aresetn = 1;

        // single fetch
        step();
        bus.inst_req = 1; bus.inst_addr = 32'h1C00_0000;
        #2 chk("f t0 inst_addr_ok", 32'(bus.inst_addr_ok), 1);
        step();
        bus.inst_req = 0; bus.arready = 1;
        #2 chk("f t1 arvalid", 32'(bus.arvalid), 1);
        chk("f t1 arid", 32'(bus.arid), 0);
        chk("f t1 araddr", bus.araddr, 32'h1C00_0000);
        step();
        bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF;
        #2 chk("f t2 inst_data_ok", 32'(bus.inst_data_ok), 1);
        chk("f t2 inst_rdata", bus.inst_rdata, 32'hDEAD_BEEF);
        chk("f t2 data_data_ok", 32'(bus.data_data_ok), 0);
        step();
        bus.rvalid = 0;

        // store with skewed readies
        step();
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h100;
        bus.data_wdata = 32'h1234_5678; bus.data_wstrb = 4'hF;
        #2 chk("s t0 data_addr_ok", 32'(bus.data_addr_ok), 1);
        step();
        bus.data_req = 0; bus.data_wr = 0; bus.awready = 1;
        #2 chk("s t1 awvalid", 32'(bus.awvalid), 1);
        chk("s t1 wvalid", 32'(bus.wvalid), 1);
        chk("s t1 awaddr", bus.awaddr, 32'h100);
        step();
        bus.awready = 0;
        #2 chk("s t2 awvalid", 32'(bus.awvalid), 0);
        chk("s t2 wvalid", 32'(bus.wvalid), 1);
        step();
        bus.wready = 1;
        #2 chk("s t3 wdata", bus.wdata, 32'h1234_5678);
        chk("s t3 bready", 32'(bus.bready), 0);
        step();
        bus.wready = 0;
        #2 chk("s t4 bready", 32'(bus.bready), 1);
        chk("s t4 wvalid", 32'(bus.wvalid), 0);
        step();
        bus.bvalid = 1;
        #2 chk("s t5 data_data_ok", 32'(bus.data_data_ok), 1);
        chk("s t5 resp_err", 32'(bus.resp_err), 0);
        step();
        bus.bvalid = 0;

        // simultaneous requests: LSU load first, IFU at next IDLE
        step();
        bus.inst_req = 1; bus.inst_addr = 32'h1C00_0004;
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h200;
        #2 chk("c t0 data_addr_ok", 32'(bus.data_addr_ok), 1);
        chk("c t0 inst_addr_ok", 32'(bus.inst_addr_ok), 0);
        step();
        bus.data_req = 0; bus.arready = 1;
        #2 chk("c t1 arid", 32'(bus.arid), 1);
        chk("c t1 araddr", bus.araddr, 32'h200);
        step();
        bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D;
        #2 chk("c t2 data_rdata", bus.data_rdata, 32'hCAFE_F00D);
        chk("c t2 inst_addr_ok", 32'(bus.inst_addr_ok), 0);
        step();
        bus.rvalid = 0;
        #2 chk("c t3 inst_addr_ok", 32'(bus.inst_addr_ok), 1);
        step();
        bus.inst_req = 0; bus.arready = 1;
        #2 chk("c t4 araddr", bus.araddr, 32'h1C00_0004);
        step();
        bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0BAD_CAFE;
        #2 chk("c t5 inst_data_ok", 32'(bus.inst_data_ok), 1);
        step();
        bus.rvalid = 0;

        // error response on a load
        step();
        bus.data_req = 1; bus.data_addr = 32'h300;
        step();
        bus.data_req = 0; bus.arready = 1;
        step();
        bus.arready = 0; bus.rvalid = 1; bus.rresp = 2'b10;
        #2 chk("e data_data_ok", 32'(bus.data_data_ok), 1);
        chk("e resp_err", 32'(bus.resp_err), 1);
        step();
        bus.rvalid = 0; bus.rresp = 0;

        // reset while waiting for read data
        step();
        bus.inst_req = 1; bus.inst_addr = 32'h1C00_0008;
        step();
        bus.inst_req = 0; bus.arready = 1;
        step();
        bus.arready = 0;
        #2 chk("r t2 rready", 32'(bus.rready), 1);
        aresetn = 0;
        step();
        aresetn = 1; bus.rvalid = 1;
        #2 chk("r t3 rready", 32'(bus.rready), 0);
        chk("r t3 arvalid", 32'(bus.arvalid), 0);
        chk("r t3 inst_data_ok", 32'(bus.inst_data_ok), 0);
        step();
        bus.rvalid = 0;

        // both requesters held high, slave always ready: 30 cycles = 10 grants
        step();
        bus.inst_req = 1; bus.data_req = 1; bus.data_wr = 0;
        bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'h5555_AAAA;
        n_ifu = 0; n_lsu = 0;
        for (int i = 0; i < 30; i++) begin
            #2;
            if (bus.inst_addr_ok) n_ifu++;
            if (bus.data_addr_ok) n_lsu++;
            step();
        end
        bus.inst_req = 0; bus.data_req = 0;
`ifdef AXI_ARB_STARVE_EN
        chk("starve ifu grants", 32'(n_ifu), 2);
        chk("starve lsu grants", 32'(n_lsu), 8);
`else
        chk("starve ifu grants", 32'(n_ifu), 0);
        chk("starve lsu grants", 32'(n_lsu), 10);
`endif
        step();
        bus.arready = 0; bus.rvalid = 0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
